// File: rtl/dct_transpose_if.sv
// AXI4-Stream bundle shared by the 2D-DCT pipeline stages.
interface axi4_stream_if #(
  parameter int DW = 16
) ();
  logic            tvalid;
  logic            tready;
  logic [DW-1:0]   tdata;
  logic            tlast;
  logic            tuser;
  logic [DW/8-1:0] tkeep;
  logic [DW/8-1:0] tstrb;

  modport master (output tvalid, tdata, tlast, tuser, tkeep, tstrb, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, tkeep, tstrb, output tready);
endinterface

// File: rtl/dct_transpose.sv
// 8x8 transpose buffer between DCT row and column passes: ping-pong bands of
// 8 lines written in raster order, drained one column vector per beat.
module dct_transpose #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_WIDTH = 1920
) (
  input logic           clk_i,
  input logic           rst_n_i,
  axi4_stream_if.slave  coef_i,
  axi4_stream_if.master col_o
);
  localparam int XW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  // bank is the address MSB, so each half is padded to a power of two
  localparam int DEPTH = 2 << XW;
  localparam int VW = 8 * DATA_WIDTH;
  localparam int SW = VW + 2;
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_st_e;

  bank_st_e        bank_q [2];
  bank_st_e        bank_d [2];
  logic [1:0]      flag_q, flag_d;
  logic            wr_bank_q, wr_bank_d;
  logic [XW-1:0]   x_q, x_d;
  logic [2:0]      line_q, line_d;
  logic            rd_bank_q, rd_bank_d;
  logic [XW-1:0]   rd_x_q, rd_x_d;
  logic            rd_all_q, rd_all_d;
  logic            rvalid_q, rvalid_d;
  logic            rtuser_q, rtuser_d;
  logic            rtlast_q, rtlast_d;
  logic [SW-1:0]   slot_q [2];
  logic [SW-1:0]   slot_d [2];
  logic            wptr_q, wptr_d;
  logic            rptr_q, rptr_d;
  logic [1:0]      cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem_q [8][DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q [8];
  logic [VW-1:0]         rdata_vec;

  logic          accept, restart, rd_go, issue, pop;
  logic [XW-1:0] eff_x;
  logic [2:0]    eff_line;

  assign coef_i.tready = !((bank_q[wr_bank_q] == BANK_FULL) ||
                           (bank_q[wr_bank_q] == BANK_DRAINING));
  assign accept = coef_i.tvalid && coef_i.tready;

  assign col_o.tvalid = (cnt_q != 2'd0);
  assign col_o.tdata  = slot_q[rptr_q][VW-1:0];
  assign col_o.tlast  = slot_q[rptr_q][VW];
  assign col_o.tuser  = slot_q[rptr_q][VW+1];
  assign col_o.tkeep  = '1;
  assign col_o.tstrb  = '1;

  always_comb begin
    rdata_vec = '0;
    for (int k = 0; k < 8; k++) rdata_vec[k*DATA_WIDTH +: DATA_WIDTH] = rdata_q[k];
  end

  always_comb begin
    bank_d    = bank_q;
    flag_d    = flag_q;
    wr_bank_d = wr_bank_q;
    x_d       = x_q;
    line_d    = line_q;
    restart   = coef_i.tuser && ((x_q != '0) || (line_q != '0));
    eff_x     = restart ? '0 : x_q;
    eff_line  = restart ? '0 : line_q;
    if (accept) begin
      x_d    = eff_x;
      line_d = eff_line;
      if ((eff_x == '0) && (eff_line == '0)) begin
        bank_d[wr_bank_q] = BANK_FILLING;
        flag_d[wr_bank_q] = coef_i.tuser;
      end
      if (coef_i.tlast) begin
        x_d = '0;
        if (eff_line == 3'd7) begin
          bank_d[wr_bank_q] = BANK_FULL;
          line_d            = '0;
          wr_bank_d         = ~wr_bank_q;
        end else begin
          line_d = eff_line + 3'd1;
        end
      end else if (eff_x != X_LAST) begin
        x_d = eff_x + XW'(1);
      end
    end

    // issue only while the skid buffer plus the RAM read stage has room
    pop       = col_o.tvalid && col_o.tready;
    cnt_d     = cnt_q + {1'b0, rvalid_q} - {1'b0, pop};
    rd_go     = (bank_q[rd_bank_q] == BANK_FULL) ||
                ((bank_q[rd_bank_q] == BANK_DRAINING) && !rd_all_q);
    issue     = rd_go && (cnt_d != 2'd2);
    rd_bank_d = rd_bank_q;
    rd_x_d    = rd_x_q;
    rd_all_d  = rd_all_q;
    rvalid_d  = issue;
    rtuser_d  = rtuser_q;
    rtlast_d  = rtlast_q;
    if (issue) begin
      bank_d[rd_bank_q] = BANK_DRAINING;
      rtuser_d          = (rd_x_q == '0) && flag_q[rd_bank_q];
      rtlast_d          = (rd_x_q == X_LAST);
      if (rd_x_q == X_LAST) begin
        rd_x_d   = '0;
        rd_all_d = 1'b1;
      end else begin
        rd_x_d = rd_x_q + XW'(1);
      end
    end

    slot_d = slot_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (rvalid_q) begin
      slot_d[wptr_q] = {rtuser_q, rtlast_q, rdata_vec};
      wptr_d         = ~wptr_q;
    end
    if (pop) begin
      rptr_d = ~rptr_q;
      if (slot_q[rptr_q][VW]) begin
        bank_d[rd_bank_q] = BANK_EMPTY;
        rd_bank_d         = ~rd_bank_q;
        rd_all_d          = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem_q[eff_line][{wr_bank_q, eff_x}] <= coef_i.tdata;
    if (issue) begin
      for (int k = 0; k < 8; k++) rdata_q[k] <= mem_q[k][{rd_bank_q, rd_x_q}];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int b = 0; b < 2; b++) begin
        bank_q[b] <= BANK_EMPTY;
        slot_q[b] <= '0;
      end
      flag_q    <= '0;
      wr_bank_q <= 1'b0;
      x_q       <= '0;
      line_q    <= '0;
      rd_bank_q <= 1'b0;
      rd_x_q    <= '0;
      rd_all_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rtuser_q  <= 1'b0;
      rtlast_q  <= 1'b0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      bank_q    <= bank_d;
      slot_q    <= slot_d;
      flag_q    <= flag_d;
      wr_bank_q <= wr_bank_d;
      x_q       <= x_d;
      line_q    <= line_d;
      rd_bank_q <= rd_bank_d;
      rd_x_q    <= rd_x_d;
      rd_all_q  <= rd_all_d;
      rvalid_q  <= rvalid_d;
      rtuser_q  <= rtuser_d;
      rtlast_q  <= rtlast_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_dct_transpose.sv
// Self-checking bench for dct_transpose: directed band scenarios plus random
// traffic compared against a band-image reference model.
module tb_dct_transpose;
  localparam int DW = 16;
  localparam int FW = 16;
  localparam int VW = 8 * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  axi4_stream_if #(.DW(DW)) coef ();
  axi4_stream_if #(.DW(VW)) col ();

  dct_transpose #(.DATA_WIDTH(DW), .FRAME_WIDTH(FW)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .coef_i (coef),
    .col_o  (col)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: band images per bank, expected vectors in emission order
  logic [DW-1:0]   ref_mem [2][8][FW];
  int              m_x = 0, m_line = 0, m_bank = 0;
  bit              m_flag [2];
  logic [VW+1:0]   exp_q [$];
  logic [VW+1:0]   got_q [$];

  task automatic check(input string name, input logic [VW+1:0] got, input logic [VW+1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic model_accept(input logic [DW-1:0] d, input logic u, input logic l);
    if (u && (m_x != 0 || m_line != 0)) begin
      m_x = 0;
      m_line = 0;
    end
    if (m_x == 0 && m_line == 0) m_flag[m_bank] = u;
    ref_mem[m_bank][m_line][m_x] = d;
    if (l) begin
      m_x = 0;
      if (m_line == 7) begin
        for (int x = 0; x < FW; x++) begin
          logic [VW+1:0] v;
          v = '0;
          for (int k = 0; k < 8; k++) v[k*DW +: DW] = ref_mem[m_bank][k][x];
          v[VW]   = (x == FW - 1);
          v[VW+1] = (x == 0) && m_flag[m_bank];
          exp_q.push_back(v);
        end
        m_bank ^= 1;
        m_line = 0;
      end else begin
        m_line++;
      end
    end else if (m_x < FW - 1) begin
      m_x++;
    end
  endtask

  always @(negedge clk) begin
    logic [VW+1:0] g;
    if (rst_n) begin
      if (coef.tvalid && coef.tready) model_accept(coef.tdata, coef.tuser, coef.tlast);
      if (col.tvalid && col.tready) begin
        g = {col.tuser, col.tlast, col.tdata};
        got_q.push_back(g);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h required no beat", g);
        end else begin
          check("model_beat", g, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l);
    int  n;
    bit  hs;
    n = 0;
    coef.tvalid = 1'b1;
    coef.tdata  = d;
    coef.tuser  = u;
    coef.tlast  = l;
    do begin
      @(negedge clk);
      hs = coef.tready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 2000);
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: coef tready got 0 required 1");
    end
    coef.tvalid = 1'b0;
    coef.tuser  = 1'b0;
    coef.tlast  = 1'b0;
  endtask

  task automatic send_line(input logic [DW-1:0] base, input int nbeats, input bit tuser_first);
    for (int x = 0; x < nbeats; x++)
      send_beat(base + DW'(x), tuser_first && (x == 0), x == nbeats - 1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check_int(name, exp_q.size(), 0);
  endtask

  typedef struct {
    int            x;
    logic [VW+1:0] exp;
  } t1_rec_t;

  t1_rec_t       t1_tab [FW];
  logic [VW+1:0] e;
  logic [DW-1:0] prev5 [FW];
  int            acc_cyc, n, guard, b5;
  bit            seen_high, rnd_done;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time exceeded, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int x = 0; x < FW; x++) begin
      t1_tab[x].x = x;
      t1_tab[x].exp = '0;
      for (int k = 0; k < 8; k++) t1_tab[x].exp[k*DW +: DW] = DW'(16 * k + x);
      t1_tab[x].exp[VW]   = (x == FW - 1);
      t1_tab[x].exp[VW+1] = (x == 0);
    end

    coef.tvalid = 1'b0;
    coef.tdata  = '0;
    coef.tuser  = 1'b0;
    coef.tlast  = 1'b0;
    coef.tkeep  = '1;
    coef.tstrb  = '1;
    col.tready  = 1'b1;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("rst_tvalid", int'(col.tvalid), 0);
    check("rst_outputs", {col.tuser, col.tlast, col.tdata}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check_int("rst_coef_tready", int'(coef.tready), 1);
    @(posedge clk);
    #1;

    // single band, table-checked, with latency measurement
    got_q.delete();
    for (int l = 0; l < 8; l++) send_line(DW'(16 * l), FW, l == 0);
    acc_cyc = cyc;
    do @(negedge clk); while (!col.tvalid && (cyc - acc_cyc) < 50);
    check_int("t1_first_valid_latency", cyc - acc_cyc, 2);
    wait_drain("t1_drain");
    check_int("t1_beat_count", got_q.size(), FW);
    for (int i = 0; i < FW && i < got_q.size(); i++)
      check($sformatf("t1_beat_x%0d", t1_tab[i].x), got_q[i], t1_tab[i].exp);

    // random traffic on both sides
    rnd_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 4; b++)
          for (int l = 0; l < 8; l++)
            for (int x = 0; x < FW; x++) begin
              while ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
              end
              send_beat(DW'($urandom), (b == 0) && (l == 0) && (x == 0), x == FW - 1);
            end
        wait_drain("t2_drain");
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          col.tready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    col.tready = 1'b1;

    // backpressure: writer must stall on the draining bank
    col.tready = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < 8; l++) send_line(DW'(16'h3000 + 256 * b + 16 * l), FW, 1'b0);
    @(negedge clk);
    check_int("t3_tready_drop", int'(coef.tready), 0);
    seen_high = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (coef.tready) seen_high = 1'b1;
    end
    check_int("t3_tready_held_low", int'(seen_high), 0);
    @(posedge clk);
    #1;
    col.tready = 1'b1;
    n = 0;
    guard = 0;
    while (n < FW && guard < 200) begin
      @(negedge clk);
      guard++;
      if (coef.tready) seen_high = 1'b1;
      if (col.tvalid && col.tready) n++;
    end
    check_int("t3_band0_beats", n, FW);
    check_int("t3_tready_low_until_last", int'(seen_high), 0);
    @(negedge clk);
    check_int("t3_tready_rise", int'(coef.tready), 1);
    wait_drain("t3_drain");

    // frame start in the middle of a band
    got_q.delete();
    for (int l = 0; l < 3; l++) send_line(DW'(16'h4800 + 16 * l), FW, 1'b0);
    for (int l = 0; l < 8; l++) send_line(DW'(16'h4000 + 16 * l), FW, l == 0);
    wait_drain("t4_drain");
    check_int("t4_beat_count", got_q.size(), FW);
    for (int x = 0; x < FW && x < got_q.size(); x++) begin
      e = '0;
      for (int k = 0; k < 8; k++) e[k*DW +: DW] = DW'(16'h4000 + 16 * k + x);
      e[VW]   = (x == FW - 1);
      e[VW+1] = (x == 0);
      check($sformatf("t4_beat_x%0d", x), got_q[x], e);
    end

    // short line 5: remaining columns keep what the bank held before
    got_q.delete();
    b5 = m_bank;
    for (int x = 0; x < FW; x++) prev5[x] = ref_mem[b5][5][x];
    for (int l = 0; l < 8; l++) send_line(DW'(16'h5000 + 16 * l), (l == 5) ? 10 : FW, 1'b0);
    wait_drain("t5_drain");
    check_int("t5_beat_count", got_q.size(), FW);
    for (int x = 0; x < FW && x < got_q.size(); x++) begin
      e = '0;
      for (int k = 0; k < 8; k++)
        e[k*DW +: DW] = (k == 5 && x >= 10) ? prev5[x] : DW'(16'h5000 + 16 * k + x);
      e[VW] = (x == FW - 1);
      check($sformatf("t5_beat_x%0d", x), got_q[x], e);
    end

    // asynchronous reset in the middle of a drain
    for (int l = 0; l < 8; l++) send_line(DW'(16'h6000 + 16 * l), FW, 1'b0);
    n = 0;
    guard = 0;
    while (n < 7 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (col.tvalid && col.tready) n++;
    end
    check_int("t6_beats_before_reset", n, 7);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_int("t6_async_tvalid", int'(col.tvalid), 0);
    exp_q.delete();
    m_x = 0;
    m_line = 0;
    m_bank = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_q.delete();
    seen_high = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (col.tvalid) seen_high = 1'b1;
    end
    check_int("t6_no_beat_after_reset", int'(seen_high), 0);
    check_int("t6_coef_tready", int'(coef.tready), 1);
    @(posedge clk);
    #1;
    for (int l = 0; l < 8; l++) send_line(DW'(16'h7000 + 16 * l), FW, 1'b0);
    wait_drain("t6_drain");
    check_int("t6_beat_count", got_q.size(), FW);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
